cache_arbiter: RTL and testbench

Shared-memory front end between the split L1 caches and the single 64-bit burst memory port at the `mp4` top level. Accepts 256-bit cacheline read requests from the I-cache and read/write requests from the D-cache. Arbitrates between the two, converts the winning request into one 4-beat burst on the memory port, and returns the assembled line with a one-cycle response pulse.

---
 rtl/cache_pkg.sv | 24 ++
 rtl/cacheline_adapter.sv | 49 ++++
 rtl/cache_arbiter.sv | 127 ++++++++++++
 tb/tb_cache_arbiter.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared width constants and enums for the L1-to-memory cacheline path.
// The I-cache and D-cache import the same constants.
package cache_pkg;
  localparam int LINE_W = 256;
  localparam int BEAT_W = 64;
  localparam int BEATS  = LINE_W / BEAT_W;
  localparam int CNT_W  = $clog2(BEATS);

  // Clears the byte-within-line bits of an address.
  localparam logic [31:0] LINE_ADDR_MASK = ~32'(LINE_W / 8 - 1);

  typedef enum logic [2:0] {
    IDLE,
    I_READ,
    D_READ,
    D_WRITE,
    DONE
  } arb_state_t;

  typedef enum logic {
    PORT_I,
    PORT_D
  } port_t;
endpackage

// File: rtl/cacheline_adapter.sv
// Beat counter and line buffer: slices a latched line into write beats and
// assembles read beats into a line, flagging the final beat.
module cacheline_adapter
  import cache_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              load_wdata_i,
  input  logic [LINE_W-1:0] wdata_i,
  input  logic              active_i,
  input  logic              is_write_i,
  input  logic              mem_resp_i,
  input  logic [BEAT_W-1:0] mem_rdata_i,
  output logic [BEAT_W-1:0] mem_wdata_o,
  output logic [LINE_W-1:0] line_o,
  output logic              burst_done_o
);
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [LINE_W-1:0] buf_q, buf_d;

  always_comb begin
    cnt_d        = cnt_q;
    buf_d        = buf_q;
    burst_done_o = 1'b0;
    if (start_i) begin
      cnt_d = '0;
      if (load_wdata_i) buf_d = wdata_i;
    end else if (active_i && mem_resp_i) begin
      // Beat k lands in line bits [64k+63:64k]; beat 0 is the low word.
      if (!is_write_i) buf_d[int'(cnt_q) * BEAT_W +: BEAT_W] = mem_rdata_i;
      cnt_d        = cnt_q + 1'b1;
      burst_done_o = (cnt_q == CNT_W'(BEATS - 1));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      buf_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      buf_q <= buf_d;
    end
  end

  assign mem_wdata_o = (active_i && is_write_i) ? buf_q[int'(cnt_q) * BEAT_W +: BEAT_W] : '0;
  assign line_o      = buf_q;
endmodule

// File: rtl/cache_arbiter.sv
// Arbitrates I-cache and D-cache line requests onto one 4-beat burst memory port
// and returns the assembled line with a one-cycle response pulse.
module cache_arbiter
  import cache_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_line_read,
  input  logic [31:0]       i_line_addr,
  output logic [LINE_W-1:0] i_line_rdata,
  output logic              i_line_resp,
  input  logic              d_line_read,
  input  logic              d_line_write,
  input  logic [31:0]       d_line_addr,
  input  logic [LINE_W-1:0] d_line_wdata,
  output logic [LINE_W-1:0] d_line_rdata,
  output logic              d_line_resp,
  output logic              mem_read,
  output logic              mem_write,
  output logic [31:0]       mem_addr,
  output logic [BEAT_W-1:0] mem_wdata,
  input  logic [BEAT_W-1:0] mem_rdata,
  input  logic              mem_resp,
  output arb_state_t        dbg_state_o
);
  // Handshake: a cache holds *_line_read/_write until its *_line_resp pulse and
  // drops it the cycle after; mem_resp acknowledges exactly one beat per cycle.
  arb_state_t        state_q, state_d;
  port_t             last_q, last_d, port_q, port_d;
  logic [31:0]       addr_q, addr_d;
  logic [LINE_W-1:0] i_rdata_q, d_rdata_q;
  logic              i_req, d_req, start, load_wdata, active, is_write, burst_done;
  logic              i_done, d_done;
  logic [LINE_W-1:0] line;

  assign i_req    = i_line_read;
  assign d_req    = d_line_read | d_line_write;
  assign active   = (state_q == I_READ) || (state_q == D_READ) || (state_q == D_WRITE);
  assign is_write = (state_q == D_WRITE);

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    port_d     = port_q;
    addr_d     = addr_q;
    start      = 1'b0;
    load_wdata = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_req || d_req) begin
          start = 1'b1;
          // On a tie the port not served last wins.
          if (i_req && (!d_req || last_q == PORT_D)) begin
            port_d  = PORT_I;
            addr_d  = i_line_addr & LINE_ADDR_MASK;
            state_d = I_READ;
          end else begin
            port_d = PORT_D;
            addr_d = d_line_addr & LINE_ADDR_MASK;
            if (d_line_write) begin
              state_d    = D_WRITE;
              load_wdata = 1'b1;
            end else begin
              state_d = D_READ;
            end
          end
        end
      end
      I_READ, D_READ, D_WRITE: begin
        if (burst_done) begin
          state_d = DONE;
          last_d  = port_q;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      last_q    <= PORT_D;
      port_q    <= PORT_D;
      addr_q    <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      port_q  <= port_d;
      addr_q  <= addr_d;
      if (i_done) i_rdata_q <= line;
      if (d_done) d_rdata_q <= line;
    end
  end

  cacheline_adapter u_adapter (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start),
    .load_wdata_i (load_wdata),
    .wdata_i      (d_line_wdata),
    .active_i     (active),
    .is_write_i   (is_write),
    .mem_resp_i   (mem_resp),
    .mem_rdata_i  (mem_rdata),
    .mem_wdata_o  (mem_wdata),
    .line_o       (line),
    .burst_done_o (burst_done)
  );

  assign i_done       = (state_q == DONE) && (port_q == PORT_I);
  assign d_done       = (state_q == DONE) && (port_q == PORT_D);
  assign i_line_resp  = i_done;
  assign d_line_resp  = d_done;
  assign i_line_rdata = i_done ? line : i_rdata_q;
  assign d_line_rdata = d_done ? line : d_rdata_q;
  assign mem_read     = (state_q == I_READ) || (state_q == D_READ);
  assign mem_write    = is_write;
  assign mem_addr     = active ? addr_q : '0;
  assign dbg_state_o  = state_q;

  a_d_rw_exclusive: assert property (@(posedge clk) disable iff (!rst)
    !(state_q == IDLE && d_line_read && d_line_write))
    else $warning("d_line_read and d_line_write both asserted; write takes priority");
endmodule

// File: tb/tb_cache_arbiter.sv
// Scoreboard bench for cache_arbiter: a negedge bus model answers bursts and
// checks beats and responses against an expected transaction queue.
module tb_cache_arbiter;
  import cache_pkg::*;

  typedef logic [LINE_W-1:0] wide_t;
  typedef struct {
    port_t       port;
    logic        wr;
    logic [31:0] addr;
    wide_t       wline;
  } txn_t;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              i_line_read = 1'b0;
  logic [31:0]       i_line_addr = '0;
  logic [LINE_W-1:0] i_line_rdata;
  logic              i_line_resp;
  logic              d_line_read = 1'b0;
  logic              d_line_write = 1'b0;
  logic [31:0]       d_line_addr = '0;
  logic [LINE_W-1:0] d_line_wdata = '0;
  logic [LINE_W-1:0] d_line_rdata;
  logic              d_line_resp;
  logic              mem_read, mem_write;
  logic [31:0]       mem_addr;
  logic [BEAT_W-1:0] mem_wdata;
  logic [BEAT_W-1:0] mem_rdata = '0;
  logic              mem_resp = 1'b0;
  arb_state_t        dbg_state;

  txn_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   gap_cfg = 0;
  int   beat = 0;
  int   gap = 0;

  cache_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .i_line_read  (i_line_read),
    .i_line_addr  (i_line_addr),
    .i_line_rdata (i_line_rdata),
    .i_line_resp  (i_line_resp),
    .d_line_read  (d_line_read),
    .d_line_write (d_line_write),
    .d_line_addr  (d_line_addr),
    .d_line_wdata (d_line_wdata),
    .d_line_rdata (d_line_rdata),
    .d_line_resp  (d_line_resp),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_resp     (mem_resp),
    .dbg_state_o  (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input wide_t act, input wide_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Memory contents: the line at 0x1220 holds 0x11..,0x22..,0x33..,0x44..
  function automatic logic [BEAT_W-1:0] mem_word(input logic [31:0] a, input int k);
    logic [31:0] la;
    la = {a[31:5], 5'b0};
    if (la == 32'h0000_1220) return {16{4'(k + 1)}};
    return {la, 24'hC0FFEE, 8'(k)};
  endfunction

  function automatic wide_t exp_line(input logic [31:0] a);
    wide_t l;
    for (int k = 0; k < BEATS; k++) l[k*BEAT_W +: BEAT_W] = mem_word(a, k);
    return l;
  endfunction

  // ---------------- bus model + response monitor ----------------
  initial begin : bus_model
    txn_t t;
    txn_t cur;
    forever begin
      @(negedge clk);
      if (!rst) begin
        mem_resp = 1'b0;
        beat     = 0;
        gap      = 0;
      end else begin
        if (i_line_resp || d_line_resp) begin
          if (exp_q.size() == 0) begin
            check_eq("resp_unexpected", wide_t'({i_line_resp, d_line_resp}), '0);
          end else begin
            t = exp_q.pop_front();
            check_eq("resp_port", wide_t'({i_line_resp, d_line_resp}),
                     wide_t'((t.port == PORT_I) ? 2'b10 : 2'b01));
            check_eq("mem_req_in_done", wide_t'({mem_read, mem_write}), '0);
            if (!t.wr && t.port == PORT_I) check_eq("i_line_rdata", i_line_rdata, exp_line(t.addr));
            if (!t.wr && t.port == PORT_D) check_eq("d_line_rdata", d_line_rdata, exp_line(t.addr));
          end
        end
        mem_resp = 1'b0;
        if (mem_read || mem_write) begin
          if (gap > 0) begin
            gap--;
          end else if (exp_q.size() == 0) begin
            check_eq("mem_req_unexpected", wide_t'({mem_read, mem_write}), '0);
          end else begin
            cur = exp_q[0];
            check_eq("mem_addr", wide_t'(mem_addr), wide_t'({cur.addr[31:5], 5'b0}));
            check_eq("mem_op", wide_t'({mem_read, mem_write}), wide_t'(cur.wr ? 2'b01 : 2'b10));
            if (cur.wr) check_eq("mem_wdata", wide_t'(mem_wdata), wide_t'(cur.wline[beat*BEAT_W +: BEAT_W]));
            mem_resp  = 1'b1;
            mem_rdata = mem_word(cur.addr, beat);
            if (beat == 1) gap = gap_cfg;
            beat = (beat + 1) % BEATS;
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input port_t p, input logic wr, input logic rd_too,
                       input logic [31:0] a, input wide_t wl);
    txn_t t;
    t.port = p; t.wr = wr; t.addr = a; t.wline = wl;
    exp_q.push_back(t);
    if (p == PORT_I) begin
      i_line_read = 1'b1;
      i_line_addr = a;
    end else begin
      d_line_read  = !wr || rd_too;
      d_line_write = wr;
      d_line_addr  = a;
      d_line_wdata = wl;
    end
  endtask

  task automatic drop_all();
    i_line_read  = 1'b0;
    d_line_read  = 1'b0;
    d_line_write = 1'b0;
  endtask

  // Latency counts the IDLE cycle that samples the request as cycle 1.
  task automatic run(input port_t p, input logic wr, input logic rd_too,
                     input logic [31:0] a, input wide_t wl, output int lat);
    bit seen;
    seen = 1'b0;
    @(negedge clk);
    issue(p, wr, rd_too, a, wl);
    lat = 1;
    for (int c = 0; c < 200 && !seen; c++) begin
      @(posedge clk); #1;
      lat++;
      seen = (p == PORT_I) ? i_line_resp : d_line_resp;
    end
    if (!seen) begin
      check_eq("resp_timeout", '0, wide_t'(1));
      lat = -1;
    end
    @(negedge clk);
    drop_all();
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_mem_req"}, wide_t'({mem_read, mem_write, i_line_resp, d_line_resp}), '0);
    check_eq({tag, "_mem_addr"}, wide_t'(mem_addr), '0);
    check_eq({tag, "_mem_wdata"}, wide_t'(mem_wdata), '0);
    check_eq({tag, "_i_rdata"}, i_line_rdata, '0);
    check_eq({tag, "_d_rdata"}, d_line_rdata, '0);
    check_eq({tag, "_state"}, wide_t'(dbg_state), wide_t'(IDLE));
  endtask

  // ---------------- test sequence ----------------
  initial begin : stimulus
    int    lat, ni, nd, ndone;
    wide_t wl;
    port_t p;
    logic  wr;

    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b1;

    // I read alone
    run(PORT_I, 1'b0, 1'b0, 32'h0000_1234, '0, lat);
    check_eq("i_read_latency", wide_t'(lat), wide_t'(6));
    check_eq("i_rdata_hold", i_line_rdata,
             {64'h4444444444444444, 64'h3333333333333333, 64'h2222222222222222, 64'h1111111111111111});

    // D write with four distinct words
    wl = {64'hDDDD_0003_0003_DDDD, 64'hCCCC_0002_0002_CCCC, 64'hBBBB_0001_0001_BBBB, 64'hAAAA_0000_0000_AAAA};
    run(PORT_D, 1'b1, 1'b0, 32'h8000_0040, wl, lat);
    check_eq("d_write_latency", wide_t'(lat), wide_t'(6));

    // Ten ties: each port re-requests right after its resp, so grants alternate
    ni = 1; nd = 1; ndone = 0;
    @(negedge clk);
    issue(PORT_I, 1'b0, 1'b0, 32'h0001_0000, '0);
    issue(PORT_D, 1'b0, 1'b0, 32'h0002_0000, '0);
    for (int c = 0; c < 2000 && ndone < 20; c++) begin
      @(posedge clk); #1;
      if (i_line_resp) begin
        ndone++;
        if (ni < 10) begin
          issue(PORT_I, 1'b0, 1'b0, 32'h0001_0000 + 32'(ni) * 32'h40, '0);
          ni++;
        end else i_line_read = 1'b0;
      end
      if (d_line_resp) begin
        ndone++;
        if (nd < 10) begin
          issue(PORT_D, 1'b0, 1'b0, 32'h0002_0000 + 32'(nd) * 32'h40, '0);
          nd++;
        end else begin
          d_line_read = 1'b0;
        end
      end
    end
    check_eq("tie_all_served", wide_t'(ndone), wide_t'(20));
    @(negedge clk);
    drop_all();
    repeat (2) @(negedge clk);

    // Two wait cycles between beats 1 and 2
    gap_cfg = 2;
    run(PORT_D, 1'b0, 1'b0, 32'h0000_5010, '0, lat);
    check_eq("gap_latency", wide_t'(lat), wide_t'(8));
    gap_cfg = 0;

    // Reset during beat 2 of a D read
    @(negedge clk);
    issue(PORT_D, 1'b0, 1'b0, 32'h0000_6000, '0);
    for (int c = 0; c < 50 && beat != 3; c++) begin
      @(negedge clk); #1;
    end
    check_eq("beat2_reached", wide_t'(beat), wide_t'(3));
    #2;
    rst = 1'b0;
    mem_resp = 1'b0;
    #1;
    check_all_zero("midburst_rst");
    exp_q.delete();
    drop_all();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    run(PORT_I, 1'b0, 1'b0, 32'h0000_7000, '0, lat);
    check_eq("post_rst_latency", wide_t'(lat), wide_t'(6));

    // D read and write together: the write burst is performed
    wl = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    run(PORT_D, 1'b1, 1'b1, 32'h0000_9000, wl, lat);
    check_eq("rw_both_latency", wide_t'(lat), wide_t'(6));

    // Random single transactions
    for (int n = 0; n < 6; n++) begin
      p  = ($urandom_range(0, 1) == 0) ? PORT_I : PORT_D;
      wr = (p == PORT_D) && ($urandom_range(0, 1) == 1);
      wl = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      run(p, wr, 1'b0, {$urandom_range(0, 32'hFFFF), 16'(n * 32)}, wl, lat);
      check_eq("rand_latency", wide_t'(lat), wide_t'(6));
    end

    repeat (3) @(negedge clk);
    check_eq("scoreboard_empty", wide_t'(exp_q.size()), '0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
